// File: rtl/seg_serial_shifter.sv
// Serialises a 64-bit segment image into an external 8-digit 7-segment shift register.
// Each frame works from a snapshot of Disp_num, so the source may change at any time.
module seg_serial_shifter #(
    parameter int CLK_DIV   = 2,
    parameter int REFRESH   = 50000,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] Disp_num,
    input  logic        start,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_lat,
    output logic        seg_clrn,
    output logic        busy,
    output logic        frame_done
);

    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam int RW = $clog2(REFRESH + 2);
    localparam bit AUTO = (REFRESH > 0);

    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] LAT_LAST = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0] REF_LAST = RW'((REFRESH > 0) ? REFRESH - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_ref;
    logic [DW-1:0]   r_div;
    logic [5:0]      r_bit;
    logic [63:0]     r_shadow;

    logic            w_ref_wrap;
    logic            w_bit_end;
    logic            w_last_bit;
    logic            w_out_bit;

    logic            w_clk_nxt;
    logic            w_sout_nxt;
    logic            w_lat_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    assign w_ref_wrap = AUTO && (r_ref == REF_LAST);
    assign w_bit_end  = (r_div == DIV_LAST);
    assign w_last_bit = (r_bit == 6'd63);
    assign w_out_bit  = MSB_FIRST ? r_shadow[63] : r_shadow[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start || w_ref_wrap) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && w_last_bit) w_state_nxt = S_LATCH;
            S_LATCH: if (r_div == LAT_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Refresh counter only advances while staying in IDLE, so leaving IDLE clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref    <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_shadow <= '0;
        end else begin
            if (AUTO && r_state == S_IDLE && w_state_nxt == S_IDLE) begin
                r_ref <= r_ref + RW'(1);
            end else begin
                r_ref <= '0;
            end

            unique case (r_state)
                S_LOAD: begin
                    r_shadow <= Disp_num;
                    r_bit    <= '0;
                    r_div    <= '0;
                end
                S_SHIFT: begin
                    if (w_bit_end) begin
                        r_div <= '0;
                        r_bit <= r_bit + 6'd1;
                        r_shadow <= MSB_FIRST ? {r_shadow[62:0], 1'b0}
                                              : {1'b0, r_shadow[63:1]};
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                S_LATCH: r_div <= r_div + DW'(1);
                default: r_div <= '0;
            endcase
        end
    end

    always_comb begin
        w_clk_nxt  = 1'b0;
        w_sout_nxt = 1'b0;
        w_lat_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        unique case (r_state)
            S_LOAD:  w_busy_nxt = 1'b1;
            S_SHIFT: begin
                w_busy_nxt = 1'b1;
                w_clk_nxt  = (r_div >= DIV_HALF);
                w_sout_nxt = w_out_bit;
            end
            S_LATCH: begin
                w_busy_nxt = 1'b1;
                w_lat_nxt  = 1'b1;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Outputs are decoded from the current state and registered, so every output
    // trails the internal state by one cycle with all relative timing preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_clk    <= 1'b0;
            seg_sout   <= 1'b0;
            seg_lat    <= 1'b0;
            seg_clrn   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg_clk    <= w_clk_nxt;
            seg_sout   <= w_sout_nxt;
            seg_lat    <= w_lat_nxt;
            seg_clrn   <= 1'b1;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_seg_serial_shifter.sv
// Bench for seg_serial_shifter: three instances (MSB-first, LSB-first, auto-refresh)
// observed by a monitor that reconstructs what the external shift register captures.
module tb_seg_serial_shifter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] disp;
    logic [2:0]  start_v;
    logic [2:0]  m_clk, m_sout, m_lat, m_clrn, m_busy, m_done;

    seg_serial_shifter #(.CLK_DIV(2), .REFRESH(0), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .Disp_num(disp), .start(start_v[0]),
        .seg_clk(m_clk[0]), .seg_sout(m_sout[0]), .seg_lat(m_lat[0]),
        .seg_clrn(m_clrn[0]), .busy(m_busy[0]), .frame_done(m_done[0]));

    seg_serial_shifter #(.CLK_DIV(2), .REFRESH(0), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .Disp_num(disp), .start(start_v[1]),
        .seg_clk(m_clk[1]), .seg_sout(m_sout[1]), .seg_lat(m_lat[1]),
        .seg_clrn(m_clrn[1]), .busy(m_busy[1]), .frame_done(m_done[1]));

    seg_serial_shifter #(.CLK_DIV(2), .REFRESH(300), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .Disp_num(disp), .start(start_v[2]),
        .seg_clk(m_clk[2]), .seg_sout(m_sout[2]), .seg_lat(m_lat[2]),
        .seg_clrn(m_clrn[2]), .busy(m_busy[2]), .frame_done(m_done[2]));

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nb[3], lat_n[3], done_n[3], rise_n[3], rise_cyc[3], done_cyc[3], hold_err[3];
    logic [63:0] cap[3];
    logic [2:0]  p_clk, p_busy, p_sout;

    initial begin
        for (int k = 0; k < 3; k++) begin
            nb[k] = 0; lat_n[k] = 0; done_n[k] = 0; rise_n[k] = 0;
            rise_cyc[k] = 0; done_cyc[k] = 0; hold_err[k] = 0; cap[k] = '0;
        end
        p_clk = '0; p_busy = '0; p_sout = '0;
    end

    // cap holds bits in arrival order: first bit clocked in ends up at cap[63].
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (m_clk[k] && !p_clk[k]) begin
                cap[k] = {cap[k][62:0], m_sout[k]};
                nb[k]++;
            end
            if (m_clk[k] && p_clk[k] && m_sout[k] !== p_sout[k]) hold_err[k]++;
            if (m_busy[k] && !p_busy[k]) begin
                rise_n[k]++;
                rise_cyc[k] = cyc;
            end
            if (m_lat[k]) lat_n[k]++;
            if (m_done[k]) begin
                done_n[k]++;
                done_cyc[k] = cyc;
            end
            p_clk[k]  = m_clk[k];
            p_busy[k] = m_busy[k];
            p_sout[k] = m_sout[k];
        end
    end

    // Expected arrival-order word for an image: bit i leaves from the top or bottom end.
    function automatic logic [63:0] model_cap(input logic [63:0] img, input bit msb);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[63 - i] = msb ? img[63 - i] : img[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int k, input logic [63:0] img, input string tag);
        int nb0, lat0, d0;
        bit got;
        logic [63:0] exp_cap;
        disp = img;
        exp_cap = model_cap(img, k != 1);
        nb0 = nb[k]; lat0 = lat_n[k]; d0 = done_n[k];
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (done_n[k] != d0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_done_timeout got=%0d want=1", tag, got);
        end
        checks++;
        if (nb[k] - nb0 !== 64) begin
            failures++;
            $display("FAIL %s_bitcount got=%0d want=64", tag, nb[k] - nb0);
        end
        checks++;
        if (cap[k] !== exp_cap) begin
            failures++;
            $display("FAIL %s_bits got=%h want=%h", tag, cap[k], exp_cap);
        end
        checks++;
        if (lat_n[k] - lat0 !== 2) begin
            failures++;
            $display("FAIL %s_lat_cycles got=%0d want=2", tag, lat_n[k] - lat0);
        end
        checks++;
        if (done_cyc[k] - rise_cyc[k] !== 259) begin
            failures++;
            $display("FAIL %s_frame_len got=%0d want=259", tag, done_cyc[k] - rise_cyc[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; disp = '0; start_v = '0;
        repeat (3) tick();
        checks++;
        if ({m_clk, m_sout, m_lat, m_clrn, m_busy, m_done} !== 18'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0",
                     {m_clk, m_sout, m_lat, m_clrn, m_busy, m_done});
        end
        @(negedge clk);
        #1 rst = 1'b1;
        checks++;
        if (m_clrn !== 3'b000) begin
            failures++;
            $display("FAIL clrn_before_edge got=%b want=000", m_clrn);
        end
        tick();
        checks++;
        if (m_clrn !== 3'b111) begin
            failures++;
            $display("FAIL clrn_after_edge got=%b want=111", m_clrn);
        end
        repeat (50) tick();
        checks++;
        if (rise_n[0] + rise_n[1] !== 0 || m_busy[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL no_frame_without_start got=%0d want=0", rise_n[0] + rise_n[1]);
        end
    endtask

    task automatic test_msb_frame();
        run_frame(0, 64'h8000_0000_0000_0001, "msb_ends");
    endtask

    task automatic test_lsb_frame();
        run_frame(1, 64'h0000_0000_0000_00FF, "lsb_ff");
        checks++;
        if (cap[1][63:56] !== 8'hFF || cap[1][55:0] !== 56'h0) begin
            failures++;
            $display("FAIL lsb_first8 got=%h want=ff00000000000000", cap[1]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) run_frame(0, {$urandom, $urandom}, "rand_msb");
        for (int n = 0; n < 2; n++) run_frame(1, {$urandom, $urandom}, "rand_lsb");
    endtask

    task automatic test_snapshot();
        int nb0, d0;
        bit got;
        disp = '0;
        nb0 = nb[0]; d0 = done_n[0];
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 200 && nb[0] - nb0 < 10; i++) tick();
        disp = '1;
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (done_n[0] != d0) got = 1'b1;
        end
        checks++;
        if (!got || cap[0] !== model_cap(64'h0, 1'b1)) begin
            failures++;
            $display("FAIL snapshot_frame got=%h want=0 done=%0d", cap[0], got);
        end
        run_frame(0, '1, "after_snapshot");
    endtask

    task automatic test_back_to_back();
        int r0, d0, c1, c2;
        logic [63:0] img;
        img = {$urandom, $urandom};
        disp = img;
        r0 = rise_n[0]; d0 = done_n[0]; c1 = 0; c2 = 0;
        start_v[0] = 1'b1;
        for (int i = 0; i < 1000 && rise_n[0] < r0 + 2; i++) begin
            tick();
            if (rise_n[0] == r0 + 1) c1 = rise_cyc[0];
        end
        c2 = rise_cyc[0];
        start_v[0] = 1'b0;
        checks++;
        if (rise_n[0] !== r0 + 2 || c2 - c1 !== 261) begin
            failures++;
            $display("FAIL held_start_gap got=%0d want=261", c2 - c1);
        end
        for (int i = 0; i < 600 && done_n[0] < d0 + 2; i++) tick();
        checks++;
        if (done_n[0] !== d0 + 2 || cap[0] !== model_cap(img, 1'b1)) begin
            failures++;
            $display("FAIL held_start_frame2 got=%h want=%h", cap[0], model_cap(img, 1'b1));
        end
        repeat (300) tick();
        checks++;
        if (rise_n[0] !== r0 + 2) begin
            failures++;
            $display("FAIL held_start_no_extra got=%0d want=%0d", rise_n[0], r0 + 2);
        end
    endtask

    task automatic test_start_ignored_and_reset();
        int nb0, r0, d0, drops;
        disp = {$urandom, $urandom};
        nb0 = nb[0]; drops = 0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 200 && nb[0] - nb0 < 20; i++) tick();
        r0 = rise_n[0];
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 200 && nb[0] - nb0 < 30; i++) begin
            tick();
            if (m_busy[0] !== 1'b1) drops++;
        end
        checks++;
        if (drops !== 0 || rise_n[0] !== r0) begin
            failures++;
            $display("FAIL start_while_busy drops=%0d rises=%0d want=0,%0d", drops, rise_n[0], r0);
        end
        d0 = done_n[0];
        #3 rst = 1'b0;
        #1;
        checks++;
        if (m_clrn[0] !== 1'b0) begin
            failures++;
            $display("FAIL midframe_clrn got=%b want=0", m_clrn[0]);
        end
        checks++;
        if (m_clk[0] !== 1'b0) begin
            failures++;
            $display("FAIL midframe_segclk got=%b want=0", m_clk[0]);
        end
        checks++;
        if (m_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL midframe_busy got=%b want=0", m_busy[0]);
        end
        repeat (3) tick();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (300) tick();
        checks++;
        if (done_n[0] !== d0 || m_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL abandoned_frame got=%0d want=%0d", done_n[0], d0);
        end
        run_frame(0, {$urandom, $urandom}, "after_reset");
    endtask

    task automatic test_refresh();
        int r0, rA, rB, d0;
        r0 = rise_n[2];
        for (int i = 0; i < 700 && rise_n[2] == r0; i++) tick();
        rA = rise_cyc[2];
        for (int i = 0; i < 700 && rise_n[2] == r0 + 1; i++) tick();
        rB = rise_cyc[2];
        checks++;
        if (rise_n[2] !== r0 + 2 || rB - rA !== 560) begin
            failures++;
            $display("FAIL refresh_period got=%0d want=560", rB - rA);
        end
        d0 = done_n[2];
        // start is held across exactly the IDLE cycle in which the refresh counter wraps
        for (int i = 0; i < 700 && cyc != rB + 557; i++) tick();
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        for (int i = 0; i < 700 && rise_n[2] == r0 + 2; i++) tick();
        rA = rise_cyc[2];
        checks++;
        if (rA - rB !== 560) begin
            failures++;
            $display("FAIL coincident_start_gap got=%0d want=560", rA - rB);
        end
        for (int i = 0; i < 700 && rise_n[2] == r0 + 3; i++) tick();
        checks++;
        if (rise_cyc[2] - rA !== 560 || done_n[2] - d0 !== 2) begin
            failures++;
            $display("FAIL coincident_single_frame gap=%0d frames=%0d want=560,2",
                     rise_cyc[2] - rA, done_n[2] - d0);
        end
    endtask

    task automatic test_sout_hold();
        checks++;
        if (hold_err[0] + hold_err[1] + hold_err[2] !== 0) begin
            failures++;
            $display("FAIL sout_hold got=%0d want=0", hold_err[0] + hold_err[1] + hold_err[2]);
        end
    endtask

    initial begin
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_random();
        test_snapshot();
        test_back_to_back();
        test_start_ignored_and_reset();
        test_refresh();
        test_sout_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
